rggen_register_adapter: RTL
===========================

Name: rggen_register_adapter

Overview:
- Upstream stage of every register block. Accepts one bus request at a time over a valid/ready request channel.
- Decodes the request against the block's base address window, then broadcasts it as a register-interface request (valid/access/address/write_data/strobe) to all registers.
- Waits for the selected register's ready, then returns status and read data over a valid/ready response channel.
- Protocol-specific front-ends (APB, AXI4-Lite, Avalon) wrap this block; it holds the shared handshake and response logic.

Parameters:
- ADDRESS_WIDTH, 8, width of local register-side address.
- LOCAL_ADDRESS_WIDTH, 8, size of the block's window is 2**LOCAL_ADDRESS_WIDTH bytes; must be <= ADDRESS_WIDTH.
- BUS_WIDTH, 32, data width; multiple of 8.
- REGISTERS, 1, number of register ports collected.
- BASE_ADDRESS, '0, ADDRESS_WIDTH bits; window start, aligned to window size.
- ERROR_STATUS, 0, 1: unmapped/out-of-window access returns RGGEN_SLAVE_ERROR; 0: returns RGGEN_OKAY.
- DEFAULT_READ_DATA, '0, BUS_WIDTH bits; read data returned for unmapped reads.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_bus_valid  in  1  request valid.
- o_bus_ready  out  1  request accepted when valid&&ready.
- i_bus_access  in  2  rggen_access; RGGEN_ACCESS_DATA_BIT=1 means write.
- i_bus_address  in  ADDRESS_WIDTH  byte address.
- i_bus_write_data  in  BUS_WIDTH  write data.
- i_bus_strobe  in  BUS_WIDTH  bit-level write strobe.
- o_bus_response_valid  out  1  response valid.
- i_bus_response_ready  in  1  response consumed.
- o_bus_status  out  2  rggen_status.
- o_bus_read_data  out  BUS_WIDTH  read data.
- o_reg_valid  out  1  register request valid.
- o_reg_access  out  2  latched access.
- o_reg_address  out  ADDRESS_WIDTH  latched address with window bits cleared (local offset).
- o_reg_write_data  out  BUS_WIDTH  latched write data.
- o_reg_strobe  out  BUS_WIDTH  latched strobe.
- i_reg_active  in  REGISTERS  per-register address match.
- i_reg_ready  in  REGISTERS  per-register ready (deasserted while backdoor access pending).
- i_reg_status  in  2*REGISTERS  per-register status.
- i_reg_read_data  in  BUS_WIDTH*REGISTERS  per-register read data.

Behaviour:
- FSM has three states: IDLE, BUSY, RESPONSE. Reset puts the FSM in IDLE.
- Reset values: o_bus_ready=1 (IDLE); o_reg_valid=0; o_bus_response_valid=0; o_bus_status=RGGEN_OKAY; o_bus_read_data=0; all latched o_reg_* fields=0.
- IDLE:
  - o_bus_ready=1.
  - On i_bus_valid, latch access/address/write_data/strobe.
  - If the address is inside the window (upper ADDRESS_WIDTH-LOCAL_ADDRESS_WIDTH bits equal BASE_ADDRESS's), go to BUSY.
  - Otherwise go directly to RESPONSE with the error response: status per ERROR_STATUS, read data DEFAULT_READ_DATA (0 for writes).
- BUSY:
  - o_reg_valid=1; o_reg_* fields stable.
  - any_active = OR of i_reg_active.
  - If !any_active: error response as above, go to RESPONSE.
  - If any_active and the OR of (active & ready) is 1:
    - Capture status and read data through an AND-OR mux selected by i_reg_active.
    - Write responses drive read data 0.
    - Go to RESPONSE.
  - Otherwise stay in BUSY (no timeout).
- RESPONSE:
  - o_bus_response_valid=1; o_bus_ready=0; status and data held stable.
  - On i_bus_response_ready, go to IDLE.
- Latency:
  - Accept in cycle N; o_reg_valid in N+1.
  - With a same-cycle ready, o_bus_response_valid in N+2.
  - Earliest next accept is the cycle after response handshake; throughput is one transaction per 3 cycles.
- o_reg_valid is high for exactly the cycles spent in BUSY; it never overlaps with o_bus_response_valid.
- Multiple active bits are illegal; the mux ORs them. An SVA checks $onehot0(i_reg_active) while o_reg_valid.
- i_bus_* changes outside IDLE acceptance are ignored.
- i_rst during BUSY or RESPONSE: next cycle IDLE, o_reg_valid=0, o_bus_response_valid=0; the pending transaction is dropped with no response.

Decomposition:
- rggen_rtl_pkg holds rggen_access, rggen_status (OKAY, EXOKAY, SLAVE_ERROR, DECODE_ERROR), RGGEN_ACCESS_DATA_BIT, and an adapter state enum rggen_adapter_state.
- The response selection uses the existing rggen_mux; no new sub-module.

Test Plan:
- Read with BASE_ADDRESS=0x00, REGISTERS=2: read 0x04, reg1 active+ready with data 0x1234_5678 -> o_reg_valid 1 cycle, response 2 cycles after accept, status OKAY, data 0x1234_5678.
- Write stall: write 0x00 data 0xA5A5_A5A5 strobe 0x0000_FFFF; reg0 holds ready low 3 cycles -> o_reg_valid high 4 cycles, o_reg_strobe stable at 0x0000_FFFF, response OKAY with data 0.
- Out-of-window: BASE_ADDRESS=0x100, ADDRESS_WIDTH=12, LOCAL_ADDRESS_WIDTH=8; read 0x200 with ERROR_STATUS=1 -> no o_reg_valid, response next cycle, SLAVE_ERROR, data DEFAULT_READ_DATA.
- Unmapped in-window: read with no active bit set -> with ERROR_STATUS=0, OKAY and data 0; with ERROR_STATUS=1, SLAVE_ERROR.
- Response backpressure: i_bus_response_ready low 5 cycles -> status and data stable, o_bus_ready=0, a new i_bus_valid is not accepted until after the handshake.
- Reset mid-BUSY: assert i_rst with ready low -> next cycle o_reg_valid=0, o_bus_ready=1, no response ever issued.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block front end: bus access kinds, response
// status codes and the adapter's FSM state encoding.
package rggen_rtl_pkg;

  // Bit positions inside an access code.
  localparam int RGGEN_ACCESS_DATA_BIT       = 0;
  localparam int RGGEN_ACCESS_NON_POSTED_BIT = 1;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_ADAPTER_IDLE     = 2'b00,
    RGGEN_ADAPTER_BUSY     = 2'b01,
    RGGEN_ADAPTER_RESPONSE = 2'b10
  } rggen_adapter_state;

  // True when the access code carries write data.
  function automatic logic rggen_is_write(input logic [1:0] access);
    return access[RGGEN_ACCESS_DATA_BIT];
  endfunction

endpackage

// File: rtl/rggen_mux.sv
// AND-OR multiplexer: each entry is gated by its select bit and the results
// are ORed. With a one-hot (or zero) select it behaves as a plain mux; with
// no select bit set the output is zero.
module rggen_mux #(
  parameter int WIDTH   = 2,
  parameter int ENTRIES = 2
) (
  input  logic [ENTRIES-1:0]       i_select,
  input  logic [WIDTH*ENTRIES-1:0] i_data,
  output logic [WIDTH-1:0]         o_data
);

  // Gate every entry by its select bit and OR them together.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      o_data = o_data | (i_data[i*WIDTH+:WIDTH] & {WIDTH{i_select[i]}});
    end
  end

endmodule

// File: rtl/rggen_register_adapter.sv
// Shared request/response engine of a register block. One bus request at a
// time is decoded against the block window, broadcast to the registers, and
// answered once the selected register is ready.
//
// Handshakes: a transfer happens on a channel in every cycle where its valid
// and ready are both high at the rising clock edge. The request channel
// (i_bus_valid/o_bus_ready) only transfers in IDLE; the response channel
// (o_bus_response_valid/i_bus_response_ready) holds status and data stable
// until it transfers. The register side has no backpressure of its own:
// o_reg_valid stays high with stable fields until an active register is ready.
module rggen_register_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH       = 8,
  parameter int                       LOCAL_ADDRESS_WIDTH = 8,
  parameter int                       BUS_WIDTH           = 32,
  parameter int                       REGISTERS           = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter bit                       ERROR_STATUS        = 1'b0,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_bus_valid,
  output logic                           o_bus_ready,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [BUS_WIDTH-1:0]           i_bus_strobe,
  output logic                           o_bus_response_valid,
  input  logic                           i_bus_response_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic                           o_reg_valid,
  output logic [1:0]                     o_reg_access,
  output logic [ADDRESS_WIDTH-1:0]       o_reg_address,
  output logic [BUS_WIDTH-1:0]           o_reg_write_data,
  output logic [BUS_WIDTH-1:0]           o_reg_strobe,
  input  logic [REGISTERS-1:0]           i_reg_active,
  input  logic [REGISTERS-1:0]           i_reg_ready,
  input  logic [2*REGISTERS-1:0]         i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_reg_read_data
);

  localparam int MUX_WIDTH = 2 + BUS_WIDTH;

  // Bits of the address that stay visible to the registers (window offset).
  localparam logic [ADDRESS_WIDTH-1:0] LOCAL_MASK =
    {ADDRESS_WIDTH{1'b1}} >> (ADDRESS_WIDTH - LOCAL_ADDRESS_WIDTH);

  localparam logic [1:0] ERROR_RESPONSE = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

  rggen_adapter_state state;

  logic                     in_window;
  logic                     any_active;
  logic                     any_ready;
  logic [MUX_WIDTH*REGISTERS-1:0] mux_in;
  logic [MUX_WIDTH-1:0]     mux_out;
  logic [1:0]               mux_status;
  logic [BUS_WIDTH-1:0]     mux_read_data;

  // Window decode: only the bits above the local offset are compared.
  generate
    if (LOCAL_ADDRESS_WIDTH < ADDRESS_WIDTH) begin : g_window
      assign in_window =
        i_bus_address[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] ==
        BASE_ADDRESS[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH];
    end else begin : g_full_window
      assign in_window = 1'b1;
    end
  endgenerate

  assign any_active = |i_reg_active;
  assign any_ready  = |(i_reg_active & i_reg_ready);

  // Pack {status, read data} per register so one mux selects both.
  generate
    for (genvar g = 0; g < REGISTERS; g++) begin : g_mux_in
      assign mux_in[g*MUX_WIDTH+:MUX_WIDTH] =
        {i_reg_status[2*g+:2], i_reg_read_data[BUS_WIDTH*g+:BUS_WIDTH]};
    end
  endgenerate

  rggen_mux #(
    .WIDTH   (MUX_WIDTH),
    .ENTRIES (REGISTERS)
  ) u_response_mux (
    .i_select (i_reg_active),
    .i_data   (mux_in),
    .o_data   (mux_out)
  );

  assign mux_status    = mux_out[MUX_WIDTH-1:BUS_WIDTH];
  assign mux_read_data = mux_out[BUS_WIDTH-1:0];

  // Adapter FSM: all bus and register outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= RGGEN_ADAPTER_IDLE;
      o_bus_ready          <= 1'b1;
      o_reg_valid          <= 1'b0;
      o_bus_response_valid <= 1'b0;
      o_bus_status         <= RGGEN_OKAY;
      o_bus_read_data      <= '0;
      o_reg_access         <= '0;
      o_reg_address        <= '0;
      o_reg_write_data     <= '0;
      o_reg_strobe         <= '0;
    end else begin
      case (state)
        RGGEN_ADAPTER_IDLE: begin
          if (i_bus_valid) begin
            o_reg_access     <= i_bus_access;
            o_reg_address    <= i_bus_address & LOCAL_MASK;
            o_reg_write_data <= i_bus_write_data;
            o_reg_strobe     <= i_bus_strobe;
            o_bus_ready      <= 1'b0;
            if (in_window) begin
              state       <= RGGEN_ADAPTER_BUSY;
              o_reg_valid <= 1'b1;
            end else begin
              // Outside the window the registers are never bothered.
              state                <= RGGEN_ADAPTER_RESPONSE;
              o_bus_response_valid <= 1'b1;
              o_bus_status         <= ERROR_RESPONSE;
              o_bus_read_data      <= rggen_is_write(i_bus_access) ? '0 : DEFAULT_READ_DATA;
            end
          end
        end
        RGGEN_ADAPTER_BUSY: begin
          if (!any_active) begin
            // In-window hole: no register claimed the address.
            state                <= RGGEN_ADAPTER_RESPONSE;
            o_reg_valid          <= 1'b0;
            o_bus_response_valid <= 1'b1;
            o_bus_status         <= ERROR_RESPONSE;
            o_bus_read_data      <= rggen_is_write(o_reg_access) ? '0 : DEFAULT_READ_DATA;
          end else if (any_ready) begin
            state                <= RGGEN_ADAPTER_RESPONSE;
            o_reg_valid          <= 1'b0;
            o_bus_response_valid <= 1'b1;
            o_bus_status         <= mux_status;
            o_bus_read_data      <= rggen_is_write(o_reg_access) ? '0 : mux_read_data;
          end
        end
        RGGEN_ADAPTER_RESPONSE: begin
          if (i_bus_response_ready) begin
            state                <= RGGEN_ADAPTER_IDLE;
            o_bus_response_valid <= 1'b0;
            o_bus_ready          <= 1'b1;
          end
        end
        default: begin
          state                <= RGGEN_ADAPTER_IDLE;
          o_bus_ready          <= 1'b1;
          o_reg_valid          <= 1'b0;
          o_bus_response_valid <= 1'b0;
        end
      endcase
    end
  end

  // At most one register may claim an address while the request is live.
  assert property (@(posedge i_clk) disable iff (i_rst)
    o_reg_valid |-> $onehot0(i_reg_active));

endmodule
